// File: rtl/mask_loader_pkg.sv
// Package for mask_loader: FSM state type, frame constants and mask geometry.
//   SYNC_BYTE_DEFAULT - frame start marker
//   MASK_BITS         - width of one 8x8, 2 bit/pixel mask
//   MASK_BYTES        - stream bytes per mask
package mask_loader_pkg;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned MASK_BITS         = 128;
    localparam int unsigned MASK_BYTES        = MASK_BITS / 8;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StCount,
        StData,
        StWrite,
        StChk
    } state_e;

endpackage

// File: rtl/mask_loader_if.sv
// Byte-stream input and mask-memory (MAU) write port of the mask loader.
//   in_data/in_valid/in_ready       - stream handshake, transfer = in_valid & in_ready
//   mau_address_mask                - mask memory write address
//   mau_write_data_mask             - assembled 128-bit mask
//   mau_wren_mask                   - one-cycle write strobe
// master: stream source / memory side; slave: the loader.
interface mask_loader_if;
    import mask_loader_pkg::*;

    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           mau_address_mask;
    logic [MASK_BITS-1:0] mau_write_data_mask;
    logic                 mau_wren_mask;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mau_address_mask,
        input  mau_write_data_mask,
        input  mau_wren_mask
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mau_address_mask,
        output mau_write_data_mask,
        output mau_wren_mask
    );

endinterface

// File: rtl/mask_assembler.sv
// Collects 16 data bytes into one mask and keeps the running XOR checksum.
//   clk, clr       - clock, synchronous active-high reset
//   clear_i        - start of a frame's data: zero byte counter and checksum
//   data_accept_i  - a data byte is transferred this cycle
//   byte_i         - the data byte
//   word_o         - mask including the byte currently presented (valid with word_full_o)
//   word_full_o    - the byte being accepted is the 16th of the mask
//   csum_o         - XOR of all data bytes accepted since clear_i
module mask_assembler
    import mask_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 clear_i,
    input  logic                 data_accept_i,
    input  logic [7:0]           byte_i,
    output logic [MASK_BITS-1:0] word_o,
    output logic                 word_full_o,
    output logic [7:0]           csum_o
);

    logic [MASK_BITS-1:0] shift_q;
    logic [3:0]           cnt_q;
    logic [7:0]           csum_q;

    // Bytes enter at the top and shift down, so after 16 bytes byte 0 is the LSB.
    always_ff @(posedge clk) begin
        if (clr) begin
            shift_q <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
        end else if (clear_i) begin
            cnt_q  <= '0;
            csum_q <= '0;
        end else if (data_accept_i) begin
            shift_q <= {byte_i, shift_q[MASK_BITS-1:8]};
            cnt_q   <= cnt_q + 4'd1;
            csum_q  <= csum_q ^ byte_i;
        end
    end

    // Full word is formed combinationally so the write can follow the last byte by one cycle.
    assign word_o      = {byte_i, shift_q[MASK_BITS-1:8]};
    assign word_full_o = data_accept_i && (cnt_q == 4'(MASK_BYTES - 1));
    assign csum_o      = csum_q;

endmodule

// File: rtl/mask_loader.sv
// Receives framed bytes (SYNC, START, COUNT, N x 16 data, CHK) and writes the assembled
// masks into mask memory while the CPU is halted.
//   clk, clr - CPU clock, synchronous active-high reset
//   alive    - CPU running; loading only while 0, rising mid-frame aborts
//   bus      - stream input and MAU write port (slave modport)
//   busy     - frame in progress
//   done     - one-cycle pulse after a frame with a good checksum
//   error    - sticky checksum/abort flag, cleared by clr or the next sync byte
module mask_loader
    import mask_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         alive,
    mask_loader_if.slave bus,
    output logic         busy,
    output logic         done,
    output logic         error
);

    state_e               state_q;
    logic [7:0]           addr_q;
    logic [7:0]           cnt_q;
    logic [MASK_BITS-1:0] data_q;
    logic                 wren_q;
    logic                 done_q;
    logic                 error_q;

    logic                 accept;
    logic [MASK_BITS-1:0] asm_word;
    logic                 asm_full;
    logic [7:0]           asm_csum;

    assign bus.in_ready = ~alive && (state_q != StWrite);
    assign accept       = bus.in_valid && bus.in_ready;

    mask_assembler u_assembler (
        .clk           (clk),
        .clr           (clr),
        .clear_i       (accept && (state_q == StCount)),
        .data_accept_i (accept && (state_q == StData)),
        .byte_i        (bus.in_data),
        .word_o        (asm_word),
        .word_full_o   (asm_full),
        .csum_o        (asm_csum)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            wren_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            wren_q <= 1'b0;
            done_q <= 1'b0;
            // CPU woke up mid-frame: give up; a strobe already on the bus still completes.
            if (alive && (state_q != StIdle)) begin
                state_q <= StIdle;
                error_q <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (accept && (bus.in_data == SYNC_BYTE)) begin
                            state_q <= StAddr;
                            error_q <= 1'b0;
                        end
                    end
                    StAddr: begin
                        if (accept) begin
                            addr_q  <= bus.in_data;
                            state_q <= StCount;
                        end
                    end
                    StCount: begin
                        if (accept) begin
                            cnt_q   <= bus.in_data;
                            state_q <= StData;
                        end
                    end
                    StData: begin
                        if (asm_full) begin
                            data_q  <= asm_word;
                            wren_q  <= 1'b1;
                            state_q <= StWrite;
                        end
                    end
                    StWrite: begin
                        addr_q <= addr_q + 8'd1;
                        if (cnt_q == 8'd0) begin
                            state_q <= StChk;
                        end else begin
                            cnt_q   <= cnt_q - 8'd1;
                            state_q <= StData;
                        end
                    end
                    StChk: begin
                        if (accept) begin
                            if (bus.in_data == asm_csum) begin
                                done_q <= 1'b1;
                            end else begin
                                error_q <= 1'b1;
                            end
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.mau_address_mask    = addr_q;
    assign bus.mau_write_data_mask = data_q;
    assign bus.mau_wren_mask       = wren_q;
    assign busy                    = (state_q != StIdle);
    assign done                    = done_q;
    assign error                   = error_q;

endmodule

// File: tb/tb_mask_loader.sv
module tb_mask_loader;
    import mask_loader_pkg::*;

    logic clk;
    logic clr;
    logic alive;
    logic busy;
    logic done;
    logic error;

    mask_loader_if bus ();

    mask_loader dut (
        .clk   (clk),
        .clr   (clr),
        .alive (alive),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0]   addr;
        logic [127:0] data;
    } wr_t;

    wr_t        obs_q[$];
    wr_t        exp_q[$];
    logic [7:0] dat_q[$];
    logic [7:0] frame_q[$];
    bit         exp_good;
    int         done_cnt;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Passive monitor: records strobes, counts done pulses, checks in_ready against state.
    always begin
        @(negedge clk);
        #2;
        if (bus.mau_wren_mask === 1'b1) begin
            obs_q.push_back({bus.mau_address_mask, bus.mau_write_data_mask});
            check("ready_low_in_write", 128'(bus.in_ready), 128'(1'b0));
        end else if (busy === 1'b1 && alive === 1'b0 && clr === 1'b0) begin
            check("ready_high_in_frame", 128'(bus.in_ready), 128'(1'b1));
        end
        if (done === 1'b1) done_cnt++;
    end

    // Reference model: frame bytes and expected writes straight from the frame format.
    task automatic make_frame(input logic [7:0] start, input logic [7:0] cnt_m1,
                              input logic [7:0] flip);
        logic [7:0]   x;
        logic [127:0] w;
        x = 8'h00;
        frame_q = {};
        exp_q   = {};
        frame_q.push_back(SYNC_BYTE_DEFAULT);
        frame_q.push_back(start);
        frame_q.push_back(cnt_m1);
        for (int m = 0; m <= int'(cnt_m1); m++) begin
            w = '0;
            for (int k = 0; k < 16; k++) begin
                w[8*k +: 8] = dat_q[m*16 + k];
                x = x ^ dat_q[m*16 + k];
                frame_q.push_back(dat_q[m*16 + k]);
            end
            exp_q.push_back({8'(int'(start) + m), w});
        end
        frame_q.push_back(x ^ flip);
        exp_good = (flip == 8'h00);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gappy);
        int n;
        if (gappy) begin
            while ($urandom_range(1, 0) == 1) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        #1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("handshake_within_budget", 128'(n < 100), 128'(1'b1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_write_count"}, 128'(obs_q.size()), 128'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({tag, "_addr"}, 128'(obs_q[i].addr), 128'(exp_q[i].addr));
            check({tag, "_data"}, obs_q[i].data, exp_q[i].data);
        end
    endtask

    task automatic send_frame(input string tag, input bit gappy);
        obs_q    = {};
        done_cnt = 0;
        foreach (frame_q[i]) send_byte(frame_q[i], gappy);
        check({tag, "_done_after_chk"}, 128'(done), 128'(exp_good));
        check({tag, "_error"}, 128'(error), 128'(!exp_good));
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_pulses"}, 128'(done_cnt), 128'(exp_good ? 1 : 0));
        check({tag, "_busy_after"}, 128'(busy), 128'(1'b0));
        check_writes(tag);
    endtask

    task automatic fill_seq(input int n);
        dat_q = {};
        for (int i = 0; i < n; i++) dat_q.push_back(8'(i));
    endtask

    task automatic fill_const(input int n, input logic [7:0] v);
        dat_q = {};
        for (int i = 0; i < n; i++) dat_q.push_back(v);
    endtask

    task automatic fill_rand(input int n);
        dat_q = {};
        for (int i = 0; i < n; i++) dat_q.push_back(8'($urandom));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rstart;
        logic [7:0] rcnt;

        clr          = 1'b1;
        alive        = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'(1'b0));
        check("rst_done", 128'(done), 128'(1'b0));
        check("rst_error", 128'(error), 128'(1'b0));
        check("rst_wren", 128'(bus.mau_wren_mask), 128'(1'b0));
        check("rst_addr", 128'(bus.mau_address_mask), 128'(8'h00));
        check("rst_data", bus.mau_write_data_mask, 128'(0));
        check("rst_ready_idle", 128'(bus.in_ready), 128'(1'b1));
        @(negedge clk);
        clr = 1'b0;

        // Single mask, ascending bytes.
        fill_seq(16);
        make_frame(8'h10, 8'h00, 8'h00);
        send_frame("t1", 1'b0);

        // Three all-ones masks across the address wrap.
        fill_const(48, 8'hFF);
        make_frame(8'hFE, 8'h02, 8'h00);
        send_frame("t2", 1'b0);

        // Bad checksum: write still happens, error sticks through idle junk.
        fill_seq(16);
        make_frame(8'h40, 8'h00, 8'h01);
        send_frame("t3", 1'b0);
        send_byte(8'h00, 1'b0);
        check("t3_error_sticky", 128'(error), 128'(1'b1));

        // Scenario 1 with random gaps; sync byte alone must clear the error.
        fill_seq(16);
        make_frame(8'h10, 8'h00, 8'h00);
        send_byte(frame_q.pop_front(), 1'b1);
        check("t4_error_cleared_by_sync", 128'(error), 128'(1'b0));
        frame_q.push_front(SYNC_BYTE_DEFAULT);
        obs_q    = {};
        done_cnt = 0;
        for (int i = 1; i < frame_q.size(); i++) send_byte(frame_q[i], 1'b1);
        check("t4_done_after_chk", 128'(done), 128'(1'b1));
        repeat (3) @(posedge clk);
        #1;
        check_writes("t4");

        // Random multi-mask frames with gaps.
        for (int r = 0; r < 3; r++) begin
            rstart = 8'($urandom);
            rcnt   = 8'($urandom_range(2, 0));
            fill_rand(16 * (int'(rcnt) + 1));
            make_frame(rstart, rcnt, 8'h00);
            send_frame("t4r", 1'b1);
        end

        // Abort by alive after the 7th data byte.
        fill_rand(16);
        make_frame(8'h20, 8'h00, 8'h00);
        obs_q = {};
        for (int i = 0; i < 10; i++) send_byte(frame_q[i], 1'b0);
        @(negedge clk);
        alive = 1'b1;
        #2;
        check("t5_ready_drops", 128'(bus.in_ready), 128'(1'b0));
        @(posedge clk);
        #1;
        check("t5_busy_after_abort", 128'(busy), 128'(1'b0));
        check("t5_error_after_abort", 128'(error), 128'(1'b1));
        repeat (3) @(posedge clk);
        #1;
        check("t5_ready_idle_alive", 128'(bus.in_ready), 128'(1'b0));
        check("t5_no_write", 128'(obs_q.size()), 128'(0));
        @(negedge clk);
        alive = 1'b0;
        send_frame("t5_resend", 1'b0);

        // Junk before sync is dropped; clr mid-DATA drops the pending write.
        obs_q = {};
        send_byte(8'h00, 1'b0);
        send_byte(8'h3C, 1'b0);
        check("t6_junk_not_busy", 128'(busy), 128'(1'b0));
        fill_rand(16);
        make_frame(8'h33, 8'h00, 8'h00);
        for (int i = 0; i < 18; i++) send_byte(frame_q[i], 1'b0);
        check("t6_busy_in_data", 128'(busy), 128'(1'b1));
        @(negedge clk);
        bus.in_data  = frame_q[18];
        bus.in_valid = 1'b1;
        clr          = 1'b1;
        @(posedge clk);
        #1;
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        check("t6_clr_busy", 128'(busy), 128'(1'b0));
        check("t6_clr_wren", 128'(bus.mau_wren_mask), 128'(1'b0));
        check("t6_clr_addr", 128'(bus.mau_address_mask), 128'(8'h00));
        check("t6_clr_data", bus.mau_write_data_mask, 128'(0));
        check("t6_clr_done", 128'(done), 128'(1'b0));
        check("t6_clr_error", 128'(error), 128'(1'b0));
        repeat (3) @(posedge clk);
        #1;
        check("t6_no_write", 128'(obs_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
